// File: rtl/dft_index_sequencer.sv
// rtl/dft_index_sequencer.sv - direct-DFT address/strobe sequencer (n over 0..N-1 per bin k)
// Optional build macro DFT_SEQ_HALF_SPECTRUM_EN: compute bins 0..floor(N/2) only.
module dft_index_sequencer #(
  parameter int ADDR_W   = 12,
  parameter int PIPE_LAT = 3
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              ce,
  input  logic              start,
  input  logic [ADDR_W-1:0] sample_num,
  output logic              busy,
  output logic [ADDR_W-1:0] n_addr,
  output logic [ADDR_W-1:0] tw_addr,
  output logic              issue_valid,
  output logic              acc_clear,
  output logic              acc_en,
  output logic              acc_dump,
  output logic [ADDR_W-1:0] res_addr,
  output logic              done,
  output logic              cfg_err
);

  localparam int CW = 4;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_len;
  logic [ADDR_W-1:0]   r_n;
  logic [ADDR_W-1:0]   r_k;
  logic [ADDR_W-1:0]   r_tw;
  logic                r_issue_valid;
  logic [CW-1:0]       r_drain_cnt;
  logic                r_done;
  logic                r_cfg_err;
  logic [PIPE_LAT-1:0] r_pv;
  logic [PIPE_LAT-1:0] r_pf;
  logic [PIPE_LAT-1:0] r_pl;
  logic [ADDR_W-1:0]   r_pk [PIPE_LAT];

  logic [ADDR_W-1:0]   w_len_m1;
  logic [ADDR_W-1:0]   w_k_last;
  logic [ADDR_W:0]     w_tw_sum;
  logic                w_tw_ge;
  logic [ADDR_W-1:0]   w_tw_next;
  logic                w_first_n;
  logic                w_last_n;
  logic                w_start_ok;

  assign w_len_m1 = r_len - 1'b1;
`ifdef DFT_SEQ_HALF_SPECTRUM_EN
  assign w_k_last = r_len >> 1;
`else
  assign w_k_last = w_len_m1;
`endif

  // (n*k) mod N built incrementally: tw<N and k<N, so one conditional subtract wraps it
  assign w_tw_sum   = {1'b0, r_tw} + {1'b0, r_k};
  assign w_tw_ge    = (w_tw_sum >= {1'b0, r_len});
  assign w_tw_next  = ADDR_W'(w_tw_ge ? (w_tw_sum - {1'b0, r_len}) : w_tw_sum);
  assign w_first_n  = (r_n == '0);
  assign w_last_n   = (r_n == w_len_m1);
  assign w_start_ok = (sample_num >= ADDR_W'(2));

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state       <= S_IDLE;
      r_len         <= '0;
      r_n           <= '0;
      r_k           <= '0;
      r_tw          <= '0;
      r_issue_valid <= 1'b0;
      r_drain_cnt   <= '0;
      r_done        <= 1'b0;
      r_cfg_err     <= 1'b0;
      r_pv          <= '0;
      r_pf          <= '0;
      r_pl          <= '0;
      for (int i = 0; i < PIPE_LAT; i++) r_pk[i] <= '0;
    end else begin
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;
      if (ce) begin
        // issue tags ride alongside the datapath so strobes meet their operands
        r_pv[0] <= r_issue_valid;
        r_pf[0] <= r_issue_valid & w_first_n;
        r_pl[0] <= r_issue_valid & w_last_n;
        r_pk[0] <= r_k;
        for (int i = 1; i < PIPE_LAT; i++) begin
          r_pv[i] <= r_pv[i-1];
          r_pf[i] <= r_pf[i-1];
          r_pl[i] <= r_pl[i-1];
          r_pk[i] <= r_pk[i-1];
        end
        case (r_state)
          S_IDLE: begin
            if (start) begin
              if (w_start_ok) begin
                r_state       <= S_RUN;
                r_len         <= sample_num;
                r_n           <= '0;
                r_k           <= '0;
                r_tw          <= '0;
                r_issue_valid <= 1'b1;
              end else begin
                r_cfg_err <= 1'b1;
              end
            end
          end
          S_RUN: begin
            if (w_last_n) begin
              r_n  <= '0;
              r_tw <= '0;
              if (r_k == w_k_last) begin
                r_state       <= S_DRAIN;
                r_issue_valid <= 1'b0;
                r_k           <= '0;
                r_drain_cnt   <= '0;
              end else begin
                r_k <= r_k + 1'b1;
              end
            end else begin
              r_n  <= r_n + 1'b1;
              r_tw <= w_tw_next;
            end
          end
          S_DRAIN: begin
            if (r_drain_cnt == CW'(PIPE_LAT - 1)) begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
            end else begin
              r_drain_cnt <= r_drain_cnt + 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign n_addr      = r_n;
  assign tw_addr     = r_tw;
  assign issue_valid = r_issue_valid;
  assign acc_en      = r_pv[PIPE_LAT-1];
  assign acc_clear   = r_pf[PIPE_LAT-1];
  assign acc_dump    = r_pl[PIPE_LAT-1];
  assign res_addr    = r_pk[PIPE_LAT-1];
  assign done        = r_done;
  assign cfg_err     = r_cfg_err;

endmodule

// File: tb/tb_dft_index_sequencer.sv
// tb/tb_dft_index_sequencer.sv - directed self-checking bench for dft_index_sequencer
module tb_dft_index_sequencer;
  localparam int ADDR_W   = 12;
  localparam int PIPE_LAT = 3;

  logic              clk = 1'b0;
  logic              nrst = 1'b0;
  logic              ce = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] sample_num = '0;
  logic              busy, issue_valid, acc_clear, acc_en, acc_dump, done, cfg_err;
  logic [ADDR_W-1:0] n_addr, tw_addr, res_addr;

  int n_tests = 0;
  int n_fail  = 0;
  int got_tw[$];
  int dump_c[$];
  int dump_k[$];
  int done_c;

  always #5 clk = ~clk;

  dft_index_sequencer #(.ADDR_W(ADDR_W), .PIPE_LAT(PIPE_LAT)) u_dut (
    .clk(clk), .nrst(nrst), .ce(ce), .start(start), .sample_num(sample_num),
    .busy(busy), .n_addr(n_addr), .tw_addr(tw_addr), .issue_valid(issue_valid),
    .acc_clear(acc_clear), .acc_en(acc_en), .acc_dump(acc_dump), .res_addr(res_addr),
    .done(done), .cfg_err(cfg_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pk(input logic iv, input logic [11:0] n, input logic [11:0] tw,
                                     input logic ae, input logic clr, input logic dmp,
                                     input logic [11:0] ra, input logic bz, input logic dn,
                                     input logic ce_);
    return {21'd0, iv, (iv ? n : 12'd0), (iv ? tw : 12'd0), ae, clr, dmp,
            (ae ? ra : 12'd0), bz, dn, ce_};
  endfunction

  function automatic logic [63:0] dut_vec();
    return pk(issue_valid, n_addr, tw_addr, acc_en, acc_clear, acc_dump, res_addr,
              busy, done, cfg_err);
  endfunction

  function automatic logic [63:0] raw();
    return {21'd0, issue_valid, n_addr, tw_addr, acc_en, acc_clear, acc_dump, res_addr,
            busy, done, cfg_err};
  endfunction

  function automatic int k_last(input int n);
`ifdef DFT_SEQ_HALF_SPECTRUM_EN
    return n / 2;
`else
    return n - 1;
`endif
  endfunction

  // expected outputs after the c-th enabled edge of a run (edge 0 samples start)
  function automatic logic [63:0] expv(input int nn, input int total, input int c, input bit en);
    bit iv, ae;
    int n, k, j, n2, k2;
    iv = (c >= 1) && (c <= total);
    n  = iv ? (c - 1) % nn : 0;
    k  = iv ? (c - 1) / nn : 0;
    j  = c - PIPE_LAT - 1;
    ae = (j >= 0) && (j < total);
    n2 = ae ? j % nn : 0;
    k2 = ae ? j / nn : 0;
    return pk(iv, 12'(n), 12'((n * k) % nn), ae, ae && (n2 == 0), ae && (n2 == nn - 1),
              12'(k2), (c <= total + PIPE_LAT), en && (c == total + PIPE_LAT + 1), 1'b0);
  endfunction

  task automatic tick(input bit en);
    ce = en;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int nn, input bit stall, input int stop_at, input bit poke);
    int total, last, c, guard;
    bit en;
    total = (k_last(nn) + 1) * nn;
    last  = total + PIPE_LAT + 2;
    got_tw.delete();
    dump_c.delete();
    dump_k.delete();
    done_c = -1;
    sample_num = 12'(nn);
    start = 1'b1;
    tick(1'b1);
    start = 1'b0;
    sample_num = 12'd2;
    c = 1;
    guard = 0;
    en = 1'b1;
    forever begin
      chk($sformatf("N%0d_c%0d", nn, c), dut_vec(), expv(nn, total, c, en));
      if (en) begin
        if (c <= total) got_tw.push_back(int'(tw_addr));
        if (acc_dump) begin
          dump_c.push_back(c);
          dump_k.push_back(int'(res_addr));
        end
        if (done) done_c = c;
      end
      if (c >= last || (stop_at > 0 && c >= stop_at)) break;
      guard++;
      if (guard > 4 * last + 64) begin
        chk("bound", 64'(c), 64'(last));
        break;
      end
      en = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      start = poke && (c == 5);
      tick(en);
      start = 1'b0;
      if (en) c++;
    end
  endtask

  initial begin
    int tw4[16];
    int tw2[4];
    int tw3k2[3];
    int nb, exp_done;
    tw4   = '{0, 0, 0, 0, 0, 1, 2, 3, 0, 2, 0, 2, 0, 3, 2, 1};
    tw2   = '{0, 0, 0, 1};
    tw3k2 = '{0, 2, 1};

    nrst = 1'b0;
    tick(1'b1);
    tick(1'b0);
    chk("reset", raw(), 64'd0);
    nrst = 1'b1;
    tick(1'b1);
    chk("idle", raw(), 64'd0);

    run(4, 1'b0, 0, 1'b0);
`ifdef DFT_SEQ_HALF_SPECTRUM_EN
    nb = 3; exp_done = 16;
`else
    nb = 4; exp_done = 20;
`endif
    chk("n4_issues", 64'(got_tw.size()), 64'(nb * 4));
    for (int i = 0; i < nb * 4 && i < got_tw.size(); i++)
      chk($sformatf("tw4_%0d", i), 64'(got_tw[i]), 64'(tw4[i]));
    chk("n4_ndump", 64'(dump_c.size()), 64'(nb));
    for (int i = 0; i < nb && i < dump_c.size(); i++) begin
      chk($sformatf("dump_cyc_%0d", i), 64'(dump_c[i]), 64'(7 + 4 * i));
      chk($sformatf("dump_k_%0d", i), 64'(dump_k[i]), 64'(i));
    end
    chk("n4_done", 64'(done_c), 64'(exp_done));

    for (int v = 0; v < 2; v++) begin
      sample_num = 12'(v);
      start = 1'b1;
      tick(1'b1);
      start = 1'b0;
      chk($sformatf("cfg_err_N%0d", v), dut_vec(), pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      tick(1'b1);
      chk($sformatf("cfg_clr_N%0d", v), raw(), 64'd0);
      tick(1'b1);
      chk($sformatf("cfg_idle_N%0d", v), raw(), 64'd0);
    end

    run(2, 1'b0, 0, 1'b0);
    chk("n2_issues", 64'(got_tw.size()), 64'd4);
    for (int i = 0; i < 4 && i < got_tw.size(); i++)
      chk($sformatf("tw2_%0d", i), 64'(got_tw[i]), 64'(tw2[i]));

    run(4, 1'b1, 0, 1'b0);
    chk("stall_ndump", 64'(dump_c.size()), 64'(nb));
    chk("stall_done", 64'(done_c), 64'(exp_done));

    run(4, 1'b0, 10, 1'b0);
    nrst = 1'b0;
    tick(1'b1);
    chk("midrun_rst", raw(), 64'd0);
    nrst = 1'b1;
    tick(1'b1);
    chk("post_rst", raw(), 64'd0);

    run(3, 1'b0, 0, 1'b1);
`ifdef DFT_SEQ_HALF_SPECTRUM_EN
    chk("n3_issues", 64'(got_tw.size()), 64'd6);
`else
    chk("n3_issues", 64'(got_tw.size()), 64'd9);
    for (int i = 0; i < 3 && i + 6 < got_tw.size(); i++)
      chk($sformatf("tw3k2_%0d", i), 64'(got_tw[i + 6]), 64'(tw3k2[i]));
`endif
    chk("n3_idle", raw(), 64'd0);

    run(5, 1'b0, 0, 1'b0);
`ifdef DFT_SEQ_HALF_SPECTRUM_EN
    chk("n5_issues", 64'(got_tw.size()), 64'd15);
`else
    chk("n5_issues", 64'(got_tw.size()), 64'd25);
`endif

    run(4095, 1'b0, 3 * 4095 + 1, 1'b0);
    nrst = 1'b0;
    tick(1'b1);
    nrst = 1'b1;
    tick(1'b1);
    chk("n4095_rst", raw(), 64'd0);

    run(100, 1'b0, 0, 1'b0);
    if (dump_k.size() > 0)
      chk("n100_last_k", 64'(dump_k[dump_k.size() - 1]), 64'(k_last(100)));
    else
      chk("n100_last_k", 64'hFFFF, 64'(k_last(100)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
